// File: rtl/square_detect.sv
// square_detect: slices a 4-bit sample stream against THRESH and measures
// high run, low run and period in samples, with lock and timeout status.
//
// Parameters: CNT_W  run-length counter width (max run 2^CNT_W-1)
//             THRESH sample is high when sample_in >= THRESH
// Ports: clk, rst_n (async active-low), en (low forces IDLE),
//        sample_en (one-clk strobe per sample), sample_in[3:0],
//        high_len/low_len[CNT_W-1:0], period[CNT_W:0],
//        meas_valid (1-cycle pulse), locked, timeout (sticky).
// Optional build macro: SQUARE_DETECT_GLITCH_FILTER_EN requires two
// consecutive samples at a new level before a transition is taken.
module square_detect #(
    parameter int CNT_W  = 8,
    parameter int THRESH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sample_en,
    input  logic [3:0]       sample_in,
    output logic [CNT_W-1:0] high_len,
    output logic [CNT_W-1:0] low_len,
    output logic [CNT_W:0]   period,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEEK,
        S_HIGH,
        S_LOW
    } state_e;

    localparam logic [4:0]   THR   = 5'(THRESH);
    localparam logic [CNT_W:0] STEP1 = (CNT_W+1)'(1);
    localparam logic [CNT_W:0] STEP2 = (CNT_W+1)'(2);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_hi_q, cnt_hi_d;
    logic [CNT_W-1:0]   cnt_lo_q, cnt_lo_d;
    logic               lvl_prev_q, lvl_prev_d;
    logic [CNT_W-1:0]   high_len_q, high_len_d;
    logic [CNT_W-1:0]   low_len_q, low_len_d;
    logic [CNT_W:0]     period_q, period_d;
    logic               meas_valid_q, meas_valid_d;
    logic               locked_q, locked_d;
    logic               timeout_q, timeout_d;
`ifdef SQUARE_DETECT_GLITCH_FILTER_EN
    logic               pend_q, pend_d;
`endif

    logic               lvl;
    logic               ev_same;
    logic               ev_change;
    logic               sat;
    logic [CNT_W:0]     step;
    logic [CNT_W:0]     sum_hi;
    logic [CNT_W:0]     sum_lo;

    assign lvl = ({1'b0, sample_in} >= THR);

    always_comb begin
        // Classify the accepted sample: same-level credit or level change.
        // step is the credit for a same-level event, or the starting
        // count of the new run for a change event.
        ev_same   = 1'b0;
        ev_change = 1'b0;
        step      = STEP1;
`ifdef SQUARE_DETECT_GLITCH_FILTER_EN
        pend_d    = pend_q;
        if (sample_en) begin
            if (lvl != lvl_prev_q) begin
                // first differing sample only arms pend; second confirms
                ev_change = pend_q;
                step      = STEP2;
                pend_d    = ~pend_q;
            end else begin
                // a reverted glitch credits both samples to this run
                ev_same   = 1'b1;
                step      = pend_q ? STEP2 : STEP1;
                pend_d    = 1'b0;
            end
        end
`else
        if (sample_en) begin
            ev_change = (lvl != lvl_prev_q);
            ev_same   = ~ev_change;
        end
`endif

        state_d      = state_q;
        cnt_hi_d     = cnt_hi_q;
        cnt_lo_d     = cnt_lo_q;
        lvl_prev_d   = lvl_prev_q;
        high_len_d   = high_len_q;
        low_len_d    = low_len_q;
        period_d     = period_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
        timeout_d    = timeout_q;
        sat          = 1'b0;
        sum_hi       = {1'b0, cnt_hi_q} + step;
        sum_lo       = {1'b0, cnt_lo_q} + step;

        if (!en) begin
            state_d    = S_IDLE;
            cnt_hi_d   = '0;
            cnt_lo_d   = '0;
            lvl_prev_d = 1'b0;
            high_len_d = '0;
            low_len_d  = '0;
            period_d   = '0;
            locked_d   = 1'b0;
            timeout_d  = 1'b0;
`ifdef SQUARE_DETECT_GLITCH_FILTER_EN
            pend_d     = 1'b0;
`endif
        end else begin
            // previous level keeps tracking in every active state,
            // including after saturation, so a later edge can restart
            if (ev_change && state_q != S_IDLE) begin
                lvl_prev_d = lvl;
            end
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_SEEK;
`ifdef SQUARE_DETECT_GLITCH_FILTER_EN
                    pend_d  = 1'b0;
`endif
                end
                S_SEEK: begin
                    if (ev_change && lvl) begin
                        cnt_hi_d = step[CNT_W-1:0];
                        cnt_lo_d = '0;
                        state_d  = S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (ev_same) begin
                        if (sum_hi[CNT_W]) begin
                            sat = 1'b1;
                        end else begin
                            cnt_hi_d = sum_hi[CNT_W-1:0];
                        end
                    end else if (ev_change) begin
                        cnt_lo_d = step[CNT_W-1:0];
                        state_d  = S_LOW;
                    end
                end
                S_LOW: begin
                    if (ev_same) begin
                        if (sum_lo[CNT_W]) begin
                            sat = 1'b1;
                        end else begin
                            cnt_lo_d = sum_lo[CNT_W-1:0];
                        end
                    end else if (ev_change) begin
                        high_len_d   = cnt_hi_q;
                        low_len_d    = cnt_lo_q;
                        period_d     = {1'b0, cnt_hi_q} + {1'b0, cnt_lo_q};
                        meas_valid_d = 1'b1;
                        locked_d     = 1'b1;
                        timeout_d    = 1'b0;
                        cnt_hi_d     = step[CNT_W-1:0];
                        cnt_lo_d     = '0;
                        state_d      = S_HIGH;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            // run too long to measure: drop lock, length outputs stay
            if (sat) begin
                timeout_d = 1'b1;
                locked_d  = 1'b0;
                cnt_hi_d  = '0;
                cnt_lo_d  = '0;
                state_d   = S_SEEK;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_hi_q     <= '0;
            cnt_lo_q     <= '0;
            lvl_prev_q   <= 1'b0;
            high_len_q   <= '0;
            low_len_q    <= '0;
            period_q     <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
`ifdef SQUARE_DETECT_GLITCH_FILTER_EN
            pend_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_hi_q     <= cnt_hi_d;
            cnt_lo_q     <= cnt_lo_d;
            lvl_prev_q   <= lvl_prev_d;
            high_len_q   <= high_len_d;
            low_len_q    <= low_len_d;
            period_q     <= period_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            timeout_q    <= timeout_d;
`ifdef SQUARE_DETECT_GLITCH_FILTER_EN
            pend_q       <= pend_d;
`endif
        end
    end

    assign high_len   = high_len_q;
    assign low_len    = low_len_q;
    assign period     = period_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_square_detect.sv
// tb_square_detect: directed bench for square_detect (default build).
// Expected measurements are queued by stimulus and popped on meas_valid.
module tb_square_detect;

    typedef struct packed {
        logic [7:0] hl;
        logic [7:0] ll;
        logic [8:0] per;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       sample_en;
    logic [3:0] sample_in;
    logic [7:0] high_len;
    logic [7:0] low_len;
    logic [8:0] period;
    logic       meas_valid;
    logic       locked;
    logic       timeout;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    square_detect #(
        .CNT_W (8),
        .THRESH(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sample_en (sample_en),
        .sample_in (sample_in),
        .high_len  (high_len),
        .low_len   (low_len),
        .period    (period),
        .meas_valid(meas_valid),
        .locked    (locked),
        .timeout   (timeout)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_high_len"}, 32'(high_len), 32'd0);
        chk({tag, "_low_len"}, 32'(low_len), 32'd0);
        chk({tag, "_period"}, 32'(period), 32'd0);
        chk({tag, "_meas_valid"}, 32'(meas_valid), 32'd0);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    task automatic run(input logic [3:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            sample_in = v;
            sample_en = 1'b1;
            @(posedge clk);
            #1;
        end
        sample_en = 1'b0;
    endtask

    task automatic push(input int hl, input int ll, input int per);
        exp_t e;
        e.hl  = 8'(hl);
        e.ll  = 8'(ll);
        e.per = 9'(per);
        exp_q.push_back(e);
    endtask

    // monitor: every meas_valid must match the oldest queued expectation
    always @(negedge clk) begin
        if (meas_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL meas_unexpected: got hl=%0d ll=%0d per=%0d, want no meas_valid",
                         high_len, low_len, period);
            end else begin
                mon_e = exp_q.pop_front();
                if (high_len !== mon_e.hl || low_len !== mon_e.ll ||
                    period !== mon_e.per || locked !== 1'b1 ||
                    timeout !== 1'b0) begin
                    failures++;
                    $display("FAIL meas: got hl=%0d ll=%0d per=%0d lk=%0b to=%0b, want hl=%0d ll=%0d per=%0d lk=1 to=0",
                             high_len, low_len, period, locked, timeout,
                             mon_e.hl, mon_e.ll, mon_e.per);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        sample_en = 1'b0;
        sample_in = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        en    = 1'b1;

        // steady tone 16/16; first rising edge is never reported
        run(4'd0, 16);
        run(4'd15, 16);
        chk("tone_locked_early", 32'(locked), 32'd0);
        run(4'd0, 16);
        push(16, 16, 32);
        run(4'd15, 16);
        chk("tone_locked", 32'(locked), 32'd1);
        run(4'd0, 16);
        push(16, 16, 32);
        run(4'd15, 16);
        run(4'd0, 16);
        push(16, 16, 32);
        run(4'd15, 16);

        // threshold boundary: 7 is low, 8 is high
        run(4'd7, 3);
        push(16, 3, 19);
        run(4'd8, 3);
        run(4'd7, 3);
        push(3, 3, 6);
        run(4'd8, 3);
        run(4'd7, 3);
        push(3, 3, 6);
        run(4'd8, 3);
        run(4'd7, 20);
        chk("thr_hold_len", 32'(high_len), 32'd3);

        // enable drop mid-LOW, with a high strobe that must be ignored
        en        = 1'b0;
        sample_in = 4'd15;
        sample_en = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("en_drop");
        en        = 1'b1;
        sample_en = 1'b0;
        run(4'd0, 4);
        run(4'd15, 5);
        run(4'd0, 6);
        push(5, 6, 11);
        run(4'd15, 1);

        // saturation: lock sample + 254 highs = 255, next one overflows
        run(4'd15, 254);
        chk("sat_pre_timeout", 32'(timeout), 32'd0);
        chk("sat_pre_locked", 32'(locked), 32'd1);
        run(4'd15, 1);
        chk("sat_timeout", 32'(timeout), 32'd1);
        chk("sat_locked", 32'(locked), 32'd0);
        chk("sat_keep_hl", 32'(high_len), 32'd5);
        run(4'd0, 5);
        run(4'd15, 5);
        chk("sat_sticky", 32'(timeout), 32'd1);
        run(4'd0, 5);
        push(5, 5, 10);
        run(4'd15, 1);
        chk("sat_clear_timeout", 32'(timeout), 32'd0);
        chk("sat_relock", 32'(locked), 32'd1);

        // single-sample glitch is a real edge without the filter
        run(4'd0, 5);
        push(1, 5, 6);
        run(4'd15, 10);
        run(4'd0, 1);
        push(10, 1, 11);
        run(4'd15, 9);
        run(4'd0, 20);
        push(9, 20, 29);
        run(4'd15, 1);

        // minimum period: 1 high + 1 low
        run(4'd0, 1);
        push(1, 1, 2);
        run(4'd15, 1);
        run(4'd0, 1);
        push(1, 1, 2);
        run(4'd15, 1);

        // async reset mid-run with sample_en active
        sample_in = 4'd15;
        sample_en = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        sample_en = 1'b0;
        run(4'd0, 3);
        run(4'd15, 3);
        run(4'd0, 3);
        push(3, 3, 6);
        run(4'd15, 1);

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
